// File: rtl/seq_detect_arbiter_if.sv
// seq_detect_arbiter_if: client request/result bundle plus the shared-detector link; SEQ_ARB_STATS_EN adds the stats counters
interface seq_detect_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]            req;
    logic [NREQ*WIDTH-1:0]      data;
    logic [NREQ-1:0]            grant;
    logic                       busy;
    logic                       det_rst;
    logic                       det_in;
    logic                       det_out;
    logic                       done;
    logic [$clog2(NREQ)-1:0]    done_id;
    logic [$clog2(WIDTH+1)-1:0] match_cnt;
`ifdef SEQ_ARB_STATS_EN
    logic [15:0]                frames_total;
    logic [15:0]                matches_total;
    modport master (
        input  req, data, det_out,
        output grant, busy, det_rst, det_in, done, done_id, match_cnt, frames_total, matches_total
    );
    modport slave (
        output req, data, det_out,
        input  grant, busy, det_rst, det_in, done, done_id, match_cnt, frames_total, matches_total
    );
`else
    modport master (
        input  req, data, det_out,
        output grant, busy, det_rst, det_in, done, done_id, match_cnt
    );
    modport slave (
        output req, data, det_out,
        input  grant, busy, det_rst, det_in, done, done_id, match_cnt
    );
`endif
endinterface

// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin sharing of one serial "101" detector; optional SEQ_ARB_STATS_EN adds frame/match totals
module seq_detect_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int DET_LAT = 2
) (
    input logic clk,
    input logic rst,
    seq_detect_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int KW = $clog2(WIDTH + DET_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     idx;
    logic              found;
    logic [WIDTH-1:0]  pick_data;
    logic [WIDTH-1:0]  sr;
    logic [KW-1:0]     k;
    logic              in_win;

    // first requester at or after the pointer, scanning the farthest offset first so the nearest wins
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        pick_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (IW'(i) == pick) pick_data = bus.data[i*WIDTH +: WIDTH];
    end

    // detector output is meaningful only once the first bit has propagated and until the last bit has
    assign in_win = (int'(k) >= DET_LAT) && (int'(k) < WIDTH + DET_LAT);

    // scheduler FSM: arbitrate, clear the detector, shift the frame LSB-first, drain, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            gidx          <= '0;
            sr            <= '0;
            k             <= '0;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.det_rst   <= 1'b1;
            bus.det_in    <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_id   <= '0;
            bus.match_cnt <= '0;
        end else begin
            if ((state == SHIFT || state == DRAIN) && bus.det_out && in_win)
                bus.match_cnt <= bus.match_cnt + 1'b1;
            case (state)
                IDLE: begin
                    bus.det_rst <= 1'b0;
                    if (found) begin
                        state         <= CLR;
                        gidx          <= pick;
                        sr            <= pick_data;
                        k             <= '0;
                        bus.grant     <= NREQ'(1) << pick;
                        bus.busy      <= 1'b1;
                        bus.det_rst   <= 1'b1;
                        bus.match_cnt <= '0;
                    end
                end
                CLR: begin
                    state       <= SHIFT;
                    bus.det_rst <= 1'b0;
                    bus.det_in  <= sr[0];
                    sr          <= sr >> 1;
                end
                SHIFT: begin
                    k <= k + 1'b1;
                    if (int'(k) == WIDTH - 1) begin
                        state      <= DRAIN;
                        bus.det_in <= 1'b0;
                    end else begin
                        bus.det_in <= sr[0];
                        sr         <= sr >> 1;
                    end
                end
                DRAIN: begin
                    k <= k + 1'b1;
                    if (int'(k) == WIDTH + DET_LAT - 1) begin
                        state       <= DONE;
                        bus.done    <= 1'b1;
                        bus.done_id <= gidx;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ptr       <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    bus.grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ARB_STATS_EN
    logic [16:0] msum;

    assign msum = {1'b0, bus.matches_total} + 17'(bus.match_cnt);

    // saturating totals, updated once per finished frame while match_cnt holds the result
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.frames_total  <= '0;
            bus.matches_total <= '0;
        end else if (state == DONE) begin
            bus.frames_total  <= (&bus.frames_total) ? bus.frames_total : bus.frames_total + 1'b1;
            bus.matches_total <= msum[16] ? 16'hFFFF : msum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb_seq_detect_arbiter: random and directed frames against a cycle-count reference of the scheduler
module tb_seq_detect_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int DET_LAT = 2;
    localparam int LAST    = WIDTH + DET_LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_hi = 1'b0;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_detect_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    seq_detect_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DET_LAT(DET_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // non-overlapping "101" occurrences, LSB first
    function automatic int ref_count(input logic [WIDTH-1:0] f);
        int n = 0;
        int i = 0;
        while (i + 2 < WIDTH) begin
            if (f[i] && !f[i+1] && f[i+2]) begin
                n++;
                i += 3;
            end else i++;
        end
        return n;
    endfunction

    function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
        return b ? ((s == 2'd2) ? 2'd3 : 2'd1) : ((s == 2'd1) ? 2'd2 : 2'd0);
    endfunction

    // reference model: m_t counts cycles since the frame was granted (0 = clear cycle)
    logic             m_act = 1'b0;
    logic             m_rst = 1'b1;
    int               m_t = 0;
    int               m_gid = 0;
    int               m_ptr = 0;
    int               m_exp = 0;
    int               m_last_id = 0;
    int               m_last_cnt = 0;
    int               m_frames = 0;
    int               m_matches = 0;
    int               g_pick;
    logic [WIDTH-1:0] m_frame = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0; m_t <= 0; m_ptr <= 0; m_last_id <= 0; m_last_cnt <= 0;
            m_rst <= 1'b1; m_frames <= 0; m_matches <= 0;
        end else begin
            m_rst <= 1'b0;
            if (!m_act) begin
                g_pick = pick_rr(bus.req, m_ptr);
                if (g_pick >= 0) begin
                    m_act   <= 1'b1;
                    m_t     <= 0;
                    m_gid   <= g_pick;
                    m_frame <= bus.data[g_pick*WIDTH +: WIDTH];
                    m_exp   <= ref_count(bus.data[g_pick*WIDTH +: WIDTH]);
                end
            end else if (m_t == LAST) begin
                m_act      <= 1'b0;
                m_ptr      <= (m_gid + 1) % NREQ;
                m_last_id  <= m_gid;
                m_last_cnt <= m_exp;
                m_frames   <= (m_frames == 65535) ? 65535 : m_frames + 1;
                m_matches  <= (m_matches + m_exp > 65535) ? 65535 : m_matches + m_exp;
            end else m_t <= m_t + 1;
        end
    end

    // external "101" Moore detector with DET_LAT cycles from det_in to det_out
    logic [1:0]         dstate = '0;
    logic [DET_LAT-1:0] dpipe = '0;

    always @(posedge clk) begin
        if (bus.det_rst) begin
            dstate <= 2'd0;
            dpipe  <= '0;
        end else begin
            dstate <= det_next(dstate, bus.det_in);
            dpipe  <= {dpipe[DET_LAT-2:0], det_next(dstate, bus.det_in) == 2'd3};
        end
    end

    // force_hi drives det_out high only where the count must ignore it
    assign bus.det_out = dpipe[DET_LAT-1] |
                         (force_hi && (!m_act || m_t <= DET_LAT || m_t > WIDTH + DET_LAT));

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 32'(bus.grant), m_act ? (32'd1 << m_gid) : 32'd0);
            check("busy", 32'(bus.busy), 32'(m_act));
            check("det_rst", 32'(bus.det_rst), 32'(m_rst || (m_act && m_t == 0)));
            check("det_in", 32'(bus.det_in),
                  (m_act && m_t >= 1 && m_t <= WIDTH) ? 32'(m_frame[m_t-1]) : 32'd0);
            check("done", 32'(bus.done), 32'(m_act && m_t == LAST));
            if (!m_act || m_t == LAST) begin
                check("done_id", 32'(bus.done_id), m_act ? m_gid : m_last_id);
                check("match_cnt", 32'(bus.match_cnt), m_act ? m_exp : m_last_cnt);
            end
            if (m_act && m_t == 0) check("match_cnt_clr", 32'(bus.match_cnt), 32'd0);
`ifdef SEQ_ARB_STATS_EN
            check("frames_total", 32'(bus.frames_total), m_frames);
            check("matches_total", 32'(bus.matches_total), m_matches);
`endif
        end
    end

    task automatic wait_done(output int id, output int cnt, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 200);
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: no done within %0d cycles", lat);
        end
        id  = int'(bus.done_id);
        cnt = int'(bus.match_cnt);
    endtask

    task automatic one_frame(input int r, input logic [WIDTH-1:0] d, output int id, output int cnt, output int lat);
        bus.data[r*WIDTH +: WIDTH] = d;
        bus.req[r] = 1'b1;
        wait_done(id, cnt, lat);
        bus.req[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] pat [6] = '{16'h0005, 16'h002D, 16'hAAAA, 16'h0015, 16'hFFFF, 16'h0000};
    int               pat_n [6] = '{1, 2, 4, 1, 0, 0};
    logic [WIDTH-1:0] rr_data [4] = '{16'h002D, 16'h0005, 16'hAAAA, 16'h0015};
    int               rr_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        int id, cnt, lat;
        bus.req  = '0;
        bus.data = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_det_rst", 32'(bus.det_rst), 32'd1);
        check("rst_det_in", 32'(bus.det_in), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);
        check("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int p = 0; p < 6; p++) begin
            check("ref_model", ref_count(pat[p]), pat_n[p]);
            one_frame(0, pat[p], id, cnt, lat);
            check("pat_id", id, 0);
            check("pat_cnt", cnt, pat_n[p]);
            check("done_latency", lat, WIDTH + DET_LAT + 2);
        end

        do_reset();
        for (int r = 0; r < NREQ; r++) bus.data[r*WIDTH +: WIDTH] = rr_data[r];
        bus.req = '1;
        for (int n = 0; n < 5; n++) begin
            wait_done(id, cnt, lat);
            check("rr_id", id, rr_seq[n]);
            if (n > 0) check("rr_spacing", lat, WIDTH + DET_LAT + 3);
        end
        bus.req = '0;
        @(negedge clk);

        one_frame(2, 16'h0005, id, cnt, lat);
        check("skip_id", id, 2);
        check("skip_latency", lat, WIDTH + DET_LAT + 2);
        bus.req = 4'b0011;
        @(negedge clk);
        check("wrap_grant", 32'(bus.grant), 32'b0001);
        wait_done(id, cnt, lat);
        check("wrap_id0", id, 0);
        wait_done(id, cnt, lat);
        check("wrap_id1", id, 1);
        bus.req = '0;
        @(negedge clk);

        bus.req[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check("abort_grant", 32'(bus.grant), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_det_rst", 32'(bus.det_rst), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        bus.req = 4'b1010;
        wait_done(id, cnt, lat);
        check("ptr_cleared_id", id, 1);
        bus.req[1] = 1'b0;
        wait_done(id, cnt, lat);
        check("after_abort_id", id, 3);
        check("after_abort_cnt", cnt, 1);
        bus.req = '0;
        @(negedge clk);

        force_hi = 1'b1;
        one_frame(0, 16'h002D, id, cnt, lat);
        check("window_cnt", cnt, 2);
        force_hi = 1'b0;

        do_reset();
        for (int n = 0; n < 3; n++) begin
            one_frame(0, 16'h002D, id, cnt, lat);
            check("stats_frame_cnt", cnt, 2);
        end
`ifdef SEQ_ARB_STATS_EN
        check("stats_frames", 32'(bus.frames_total), 32'd3);
        check("stats_matches", 32'(bus.matches_total), 32'd6);
`endif

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 699) == 0);
            force_hi = ($urandom_range(0, 2) == 0);
            for (int r = 0; r < NREQ; r++) begin
                bus.data[r*WIDTH +: WIDTH] = WIDTH'($urandom);
                if (bus.done === 1'b1 && int'(bus.done_id) == r) begin
                    if ($urandom_range(0, 1) == 1) bus.req[r] = 1'b0;
                end else if (!bus.req[r] && $urandom_range(0, 3) == 0) bus.req[r] = 1'b1;
            end
        end

        rst = 1'b0;
        bus.req = '0;
        for (int w = 0; w < 100 && bus.busy !== 1'b0; w++) @(negedge clk);
        check("drain_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
